butterfly_pipe: RTL and testbench
=================================

# butterfly_pipe

Parametrised, fully pipelined radix-2 DIT butterfly for the FFT datapath. Computes y = a + b·tf and z = a − b·tf on packed complex operands with a fixed-point twiddle, convergent-free round-half-up rounding, optional per-transaction divide-by-2 scaling and a sticky overflow flag. Sits between the twiddle ROM/operand fetch and the stage memory write-back. A valid/ready handshake provides full back-pressure, so one transaction per cycle is sustained.

## Interface
- DW, 16: bits per real/imag component of a, b, y, z (≥ 4)
- TW, 16: bits per twiddle component; Q1.(TW−1) signed fixed point (≥ 4)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands this cycle
- in_scale  in  1  divide results by 2 for this transaction
- a  in  2·DW  {re, im}, re in upper half, two's complement
- b  in  2·DW  same packing as a
- tf  in  2·TW  twiddle {re, im}, re in upper half
- out_valid  out  1  y/z valid
- out_ready  in  1  downstream accepts y/z
- y  out  2·DW  a + b·tf, same packing
- z  out  2·DW  a − b·tf, same packing
- ovf  out  1  sticky: any result component exceeded DW range
- ovf_clr  in  1  synchronous clear of ovf

## Operation
- One clock; reset is asynchronous and active-low (reset_n); all registers and outputs reset while reset_n = 0.
- Three stages, each with a valid bit. A stage loads when it is empty or its contents move on this cycle. in_ready = !v1 | advance1; out_valid = v3; stage 3 drains when out_ready = 1.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready. y/z/out_valid hold steady while out_valid & !out_ready.
- S1: register a, in_scale and the four products br·tr, bi·ti, br·ti, bi·tr (DW+TW bits each).
- S2: p_re = br·tr − bi·ti, p_im = br·ti + bi·tr (DW+TW+1 bits); round by adding 2^(TW−2), arithmetic shift right by TW−1; keep DW+2 bits.
- S3: y = a + p, z = a − p per component at DW+3 bits. If the scale bit is set: add 1, arithmetic shift right by 1. Reduce to DW bits (see Configuration).
- ovf sets when any of the four S3 results, before reduction, is outside [−2^(DW−1), 2^(DW−1)−1] on a cycle where S3 loads. ovf_clr clears it; a simultaneous set wins over clear.
- Reset mid-operation: all valid bits clear and in-flight data is discarded. ovf = 0. After release, in_ready = 1 on the first clock.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with out_ready held at 1.
- Throughput: 1 transaction/cycle with no bubbles while out_ready = 1.
- in_ready is combinational from out_ready through the stage valids; there is no other comb path from input to output.
- Reset values: in_ready = 1 (once released), out_valid = 0, y = 0, z = 0, ovf = 0.
- Full pipe with out_ready = 0: in_ready = 0 in the same cycle. When out_ready rises, all stages shift that cycle and in_ready = 1.

## Configuration
- BUTTERFLY_SATURATE_EN defined: out-of-range results clamp to 2^(DW−1)−1 or −2^(DW−1).
- Not defined: results wrap, keeping the low DW bits.
- ovf behaves identically in both builds.

## Structure
- Shared package fft_pkg: complex-word typedef parametrised by width, pack/unpack helpers, and rounding constant functions (ROUND_OFS(TW), SHIFT(TW)).
- One sub-module is natural: cmul_round, covering stages S1–S2 (complex multiply plus rounding, with stage-enable inputs). It is reused by the later radix-4 block.

## Test plan
All cases use DW = TW = 16.
- a = (1000, −500), b = (200, 300), tf = 0x7FFF_0000, scale = 0 → y = (1200, −200), z = (800, −800) exactly 3 cycles after transfer.
- a = (0, 0), b = (200, 300), tf = 0x0000_8000 (−j) → y = (300, −200), z = (−300, 200).
- a = (32767, 0), b = (32767, 0), tf = 0x7FFF_0000, scale = 0 → SAT build: y.re = 32767, ovf = 1; wrap build: y.re = −3. z.re = 1 in both.
- Same operands with scale = 1 → y.re = 32767, z.re = 1 (rounded), ovf stays 0.
- Stream 20 random transactions with out_ready toggling pseudo-randomly → outputs match the reference model in order, with no loss or duplication; y/z stay stable while stalled.
- Three transactions in flight, then pulse reset_n low for 1 cycle → out_valid = 0, ovf = 0, and no stale output after release.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, complex-word packing for
// the default width, and the constants that drive twiddle-product rounding.
package fft_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int TW_DEFAULT = 16;

    // Complex word at the default width, re in the upper half.
    typedef struct packed {
        logic signed [DW_DEFAULT-1:0] re;
        logic signed [DW_DEFAULT-1:0] im;
    } cplx16_t;

    function automatic cplx16_t cplx16_unpack(input logic [2*DW_DEFAULT-1:0] w);
        return cplx16_t'(w);
    endfunction

    function automatic logic [2*DW_DEFAULT-1:0] cplx16_pack(input cplx16_t c);
        return {c.re, c.im};
    endfunction

    // Twiddles are Q1.(tw-1): the product carries tw-1 fractional bits.
    function automatic int SHIFT(input int tw);
        return tw - 1;
    endfunction

    // Half an LSB of the result, added before the shift for round-half-up.
    function automatic longint ROUND_OFS(input int tw);
        return longint'(1) << (tw - 2);
    endfunction

endpackage

// File: rtl/cmul_round.sv
// Two-stage complex multiply b*tf with round-half-up back to DW+2 bits.
// Stage enables come from the owning pipeline's handshake logic.
module cmul_round
    import fft_pkg::*;
#(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en_s1,
    input  logic                 en_s2,
    input  logic [2*DW-1:0]      b,
    input  logic [2*TW-1:0]      tf,
    output logic signed [DW+1:0] p_re,
    output logic signed [DW+1:0] p_im
);

    localparam int PRW = DW + TW;
    localparam int PSW = DW + TW + 1;
    localparam int SHF = SHIFT(TW);
    localparam logic signed [PSW-1:0] RND = PSW'(ROUND_OFS(TW));

    logic signed [DW-1:0] b_re, b_im;
    logic signed [TW-1:0] t_re, t_im;

    assign {b_re, b_im} = b;
    assign {t_re, t_im} = tf;

    logic signed [PRW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
    logic signed [PSW-1:0] sum_re, sum_im;

    // S1: the four partial products
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_p1 <= '0;
            ii_p1 <= '0;
            ri_p1 <= '0;
            ir_p1 <= '0;
        end else if (en_s1) begin
            rr_p1 <= PRW'(b_re) * PRW'(t_re);
            ii_p1 <= PRW'(b_im) * PRW'(t_im);
            ri_p1 <= PRW'(b_re) * PRW'(t_im);
            ir_p1 <= PRW'(b_im) * PRW'(t_re);
        end
    end

    assign sum_re = PSW'(rr_p1) - PSW'(ii_p1) + RND;
    assign sum_im = PSW'(ri_p1) + PSW'(ir_p1) + RND;

    // S2: combine, round and drop the fractional bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en_s2) begin
            p_re <= (DW+2)'(sum_re >>> SHF);
            p_im <= (DW+2)'(sum_im >>> SHF);
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: y = a + b*tf, z = a - b*tf, with
// optional per-transaction halving, sticky overflow and full back-pressure.
// Build option: BUTTERFLY_SATURATE_EN clamps out-of-range results; without it
// results wrap to the low DW bits.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_scale,
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    input  logic [2*TW-1:0] tf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] y,
    output logic [2*DW-1:0] z,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int W3 = DW + 3;
    localparam logic signed [W3-1:0] MAX3 = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [W3-1:0] MIN3 = {4'b1111, {(DW-1){1'b0}}};
    localparam logic signed [W3-1:0] ONE3 = W3'(1);
    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

    // Optional halving with round-half-up.
    function automatic logic signed [W3-1:0] scale_res(input logic signed [W3-1:0] x,
                                                       input logic s);
        logic signed [W3-1:0] t;
        t = x + ONE3;
        return s ? (t >>> 1) : x;
    endfunction

    function automatic logic in_range(input logic signed [W3-1:0] x);
        return (x <= MAX3) && (x >= MIN3);
    endfunction

    // Reduce a widened result to DW bits.
    function automatic logic signed [DW-1:0] reduce(input logic signed [W3-1:0] x);
`ifdef BUTTERFLY_SATURATE_EN
        if (x > MAX3)
            return DMAX;
        else if (x < MIN3)
            return DMIN;
        else
            return DW'(x);
`else
        return DW'(x);
`endif
    endfunction

    logic vld_p1, vld_p2, vld_p3;
    logic ld_p1, ld_p2, ld_p3;

    // A stage loads when it is empty or its content moves on this cycle.
    assign ld_p3     = !vld_p3 || out_ready;
    assign ld_p2     = !vld_p2 || ld_p3;
    assign ld_p1     = !vld_p1 || ld_p2;
    assign in_ready  = ld_p1;
    assign out_valid = vld_p3;

    logic signed [DW-1:0] a_re, a_im;
    assign {a_re, a_im} = a;

    logic signed [DW-1:0] a_re_p1, a_im_p1, a_re_p2, a_im_p2;
    logic                 scale_p1, scale_p2;
    logic signed [DW+1:0] p_re_p2, p_im_p2;
    logic [2*DW-1:0]      y_p3, z_p3;

    // Valid bits travel with their stage's data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (ld_p1) vld_p1 <= in_valid;
            if (ld_p2) vld_p2 <= vld_p1;
            if (ld_p3) vld_p3 <= vld_p2;
        end
    end

    // S1/S2: carry a and the scale bit alongside the multiplier
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_re_p1  <= '0;
            a_im_p1  <= '0;
            scale_p1 <= 1'b0;
            a_re_p2  <= '0;
            a_im_p2  <= '0;
            scale_p2 <= 1'b0;
        end else begin
            if (ld_p1) begin
                a_re_p1  <= a_re;
                a_im_p1  <= a_im;
                scale_p1 <= in_scale;
            end
            if (ld_p2) begin
                a_re_p2  <= a_re_p1;
                a_im_p2  <= a_im_p1;
                scale_p2 <= scale_p1;
            end
        end
    end

    cmul_round #(
        .DW(DW),
        .TW(TW)
    ) u_cmul (
        .clock  (clock),
        .reset_n(reset_n),
        .en_s1  (ld_p1),
        .en_s2  (ld_p2),
        .b      (b),
        .tf     (tf),
        .p_re   (p_re_p2),
        .p_im   (p_im_p2)
    );

    // S3: add/subtract, scale, range check and reduce
    logic signed [W3-1:0] yre_w, yim_w, zre_w, zim_w;
    logic                 ovf_hit;

    assign yre_w = scale_res(W3'(a_re_p2) + W3'(p_re_p2), scale_p2);
    assign yim_w = scale_res(W3'(a_im_p2) + W3'(p_im_p2), scale_p2);
    assign zre_w = scale_res(W3'(a_re_p2) - W3'(p_re_p2), scale_p2);
    assign zim_w = scale_res(W3'(a_im_p2) - W3'(p_im_p2), scale_p2);

    assign ovf_hit = vld_p2 && ld_p3 &&
                     !(in_range(yre_w) && in_range(yim_w) &&
                       in_range(zre_w) && in_range(zim_w));

    // Output registers hold while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_p3 <= '0;
            z_p3 <= '0;
        end else if (ld_p3) begin
            y_p3 <= {reduce(yre_w), reduce(yim_w)};
            z_p3 <= {reduce(zre_w), reduce(zim_w)};
        end
    end

    // Sticky overflow; a new overflow takes priority over a clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (ovf_hit)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    assign y = y_p3;
    assign z = z_p3;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe at DW = TW = 16.
module tb_butterfly_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_scale = 1'b0;
    logic [31:0] a = '0, b = '0, tf = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y, z;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    butterfly_pipe #(.DW(16), .TW(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_scale (in_scale),
        .a        (a),
        .b        (b),
        .tf       (tf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .z        (z),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    function automatic logic [31:0] cx(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    // Reference: exact integer arithmetic of the butterfly, returns {y, z}.
    function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic [31:0] tfv, input logic s,
                                          output logic ov);
        longint ar, ai, br, bi, tr, ti, pr, pi, lv;
        longint r[4];
        logic [15:0] o[4];
        ar = longint'($signed(av[31:16]));  ai = longint'($signed(av[15:0]));
        br = longint'($signed(bv[31:16]));  bi = longint'($signed(bv[15:0]));
        tr = longint'($signed(tfv[31:16])); ti = longint'($signed(tfv[15:0]));
        pr = (br * tr - bi * ti + 16384) >>> 15;
        pi = (br * ti + bi * tr + 16384) >>> 15;
        r[0] = ar + pr; r[1] = ai + pi; r[2] = ar - pr; r[3] = ai - pi;
        ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lv = r[k];
            if (s) lv = (lv + 1) >>> 1;
            if (lv > 32767 || lv < -32768) ov = 1'b1;
`ifdef BUTTERFLY_SATURATE_EN
            if (lv > 32767) lv = 32767;
            if (lv < -32768) lv = -32768;
`endif
            o[k] = lv[15:0];
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    // Send one transaction with out_ready high and capture the first result.
    task automatic run_one(input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] tfv, input logic s,
                           output logic [31:0] yv, output logic [31:0] zv,
                           output int lat);
        @(negedge clock);
        a = av; b = bv; tf = tfv; in_scale = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        lat = -1; yv = '0; zv = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (out_valid && lat < 0) begin
                lat = c; yv = y; zv = z;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
        checks++; if (z !== 32'h0) begin errors++; $display("FAIL reset_z got %h want 0", z); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL released_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_unity_twiddle();
        logic [31:0] yv, zv; int lat;
        run_one(cx(1000, -500), cx(200, 300), 32'h7FFF_0000, 1'b0, yv, zv, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL latency got %0d want 3", lat); end
        checks++; if (yv !== cx(1200, -200)) begin errors++; $display("FAIL unity_y got %h want %h", yv, cx(1200, -200)); end
        checks++; if (zv !== cx(800, -800)) begin errors++; $display("FAIL unity_z got %h want %h", zv, cx(800, -800)); end
    endtask

    task automatic test_minus_j();
        logic [31:0] yv, zv; int lat;
        run_one(cx(0, 0), cx(200, 300), 32'h0000_8000, 1'b0, yv, zv, lat);
        checks++; if (yv !== cx(300, -200)) begin errors++; $display("FAIL minus_j_y got %h want %h", yv, cx(300, -200)); end
        checks++; if (zv !== cx(-300, 200)) begin errors++; $display("FAIL minus_j_z got %h want %h", zv, cx(-300, 200)); end
    endtask

    task automatic test_overflow();
        logic [31:0] yv, zv; int lat;
        logic [15:0] want_yre;
`ifdef BUTTERFLY_SATURATE_EN
        want_yre = 16'h7FFF;
`else
        want_yre = 16'hFFFD;
`endif
        run_one(cx(32767, 0), cx(32767, 0), 32'h7FFF_0000, 1'b0, yv, zv, lat);
        checks++; if (yv[31:16] !== want_yre) begin errors++; $display("FAIL ovf_y_re got %h want %h", yv[31:16], want_yre); end
        checks++; if (zv[31:16] !== 16'h0001) begin errors++; $display("FAIL ovf_z_re got %h want 0001", zv[31:16]); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;
        #1;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    task automatic test_scale();
        logic [31:0] yv, zv; int lat;
        run_one(cx(32767, 0), cx(32767, 0), 32'h7FFF_0000, 1'b1, yv, zv, lat);
        checks++; if (yv[31:16] !== 16'h7FFF) begin errors++; $display("FAIL scale_y_re got %h want 7fff", yv[31:16]); end
        checks++; if (zv[31:16] !== 16'h0001) begin errors++; $display("FAIL scale_z_re got %h want 0001", zv[31:16]); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL scale_ovf got %b want 0", ovf); end
    endtask

    task automatic test_stall();
        logic [63:0] q[$];
        logic [63:0] e;
        logic ov;
        logic [31:0] av, bv, tv;
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            av = $urandom; bv = $urandom; tv = $urandom;
            a = av; b = bv; tf = tv; in_scale = 1'b0; in_valid = 1'b1;
            #1;
            if (i == 3) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
                out_ready = 1'b1;
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
                if (out_valid && out_ready) begin
                    e = q.pop_front(); seen++;
                    checks++; if ({y, z} !== e) begin errors++; $display("FAIL stall_out got %h want %h", {y, z}, e); end
                end
            end
            if (in_valid && in_ready) q.push_back(model(av, bv, tv, 1'b0, ov));
            @(posedge clock);
            #1 in_valid = 1'b0;
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clock);
            if (out_valid) begin
                e = q.pop_front(); seen++;
                checks++; if ({y, z} !== e) begin errors++; $display("FAIL stall_out got %h want %h", {y, z}, e); end
            end
        end
        checks++; if (seen !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", seen); end
    endtask

    task automatic test_back_to_back(input int n, input bit rand_ready);
        logic [63:0] q[$];
        logic [63:0] e, prev_yz;
        logic ov, want_ovf, prev_stall;
        logic [31:0] av, bv, tv;
        logic sv;
        int sent = 0, got = 0, cycles = 0;
        @(negedge clock); ovf_clr = 1'b1;
        @(negedge clock); ovf_clr = 1'b0;
        want_ovf = 1'b0; prev_stall = 1'b0; prev_yz = '0;
        while (got < n && cycles < 2000) begin
            @(negedge clock);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {y, z} !== prev_yz) begin
                    errors++; $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, {y, z}, prev_yz);
                end
            end
            if (sent < n) begin
                av = $urandom; bv = $urandom; tv = $urandom; sv = 1'($urandom_range(0, 1));
                a = av; b = bv; tf = tv; in_scale = sv; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!rand_ready && in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL throughput_in_ready got %b want 1", in_ready); end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(av, bv, tv, sv, ov));
                want_ovf = want_ovf | ov;
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra got %h want none", {y, z});
                end else begin
                    e = q.pop_front();
                    if ({y, z} !== e) begin errors++; $display("FAIL stream_data got %h want %h", {y, z}, e); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_yz = {y, z};
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got !== n) begin errors++; $display("FAIL stream_count got %0d want %0d", got, n); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL stream_left got %0d want 0", q.size()); end
        checks++; if (ovf !== want_ovf) begin errors++; $display("FAIL stream_ovf got %b want %b", ovf, want_ovf); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a = (i == 0) ? cx(32767, 0) : 32'($urandom);
            b = (i == 0) ? cx(32767, 0) : 32'($urandom);
            tf = 32'h7FFF_0000; in_scale = 1'b0; in_valid = 1'b1;
            @(posedge clock);
            #1 in_valid = 1'b0;
        end
        @(negedge clock);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL inflight_ovf got %b want 1", ovf); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %b want 0", ovf); end
        @(negedge clock);
        reset_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postreset_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL stale_output got %0d want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_unity_twiddle();
        test_minus_j();
        test_overflow();
        test_scale();
        test_stall();
        test_back_to_back(20, 1'b1);
        test_back_to_back(12, 1'b0);
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
